// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// General-purpose register file for the multi-cycle MIPS core: 2**ADDR_WIDTH
// registers of DATA_WIDTH bits, two combinational read ports and one
// synchronous write port. Register 0 is hardwired to zero.
//
// Optional feature (compile-time macro):
//   REGFILE_WR_BYPASS_EN - write-through forwarding. While a write is being
//                          presented (wr_en=1, reset high, wr_num!=0), a read
//                          port addressing wr_num returns wr_data in the same
//                          cycle. Storage timing is unchanged.
//   Undefined (default)  - reads return stored contents only; a read of the
//                          register being written shows the old value until
//                          the clock edge.
//
// Ports:
//   clk       in   1           rising-edge clock for all state updates
//   reset     in   1           asynchronous, active-low; clears every register
//   wr_num    in   ADDR_WIDTH  destination register number
//   wr_data   in   DATA_WIDTH  write data
//   wr_en     in   1           write enable, sampled on posedge clk
//   rd0_num   in   ADDR_WIDTH  read port 0 register number
//   rd0_data  out  DATA_WIDTH  read port 0 data (combinational)
//   rd1_num   in   ADDR_WIDTH  read port 1 register number
//   rd1_data  out  DATA_WIDTH  read port 1 data (combinational)
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wr_num,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] rd0_num,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic [ADDR_WIDTH-1:0] rd1_num,
    output logic [DATA_WIDTH-1:0] rd1_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // A write that actually lands in storage (R0 writes are dropped).
    logic wr_fire;
    assign wr_fire = wr_en && (wr_num != '0);

    // Storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[wr_num] <= wr_data;
        end
    end

    // Read port 0. R0 is forced to zero at the port, so it reads 0 regardless
    // of storage contents or forwarding.
    always_comb begin
        rd0_data = '0;
        if (rd0_num != '0) begin
            rd0_data = regs[rd0_num];
`ifdef REGFILE_WR_BYPASS_EN
            // reset gate keeps forwarding off while storage is held clear.
            if (reset && wr_fire && (rd0_num == wr_num)) begin
                rd0_data = wr_data;
            end
`endif
        end
    end

    // Read port 1, identical and independent of port 0.
    always_comb begin
        rd1_data = '0;
        if (rd1_num != '0) begin
            rd1_data = regs[rd1_num];
`ifdef REGFILE_WR_BYPASS_EN
            if (reset && wr_fire && (rd1_num == wr_num)) begin
                rd1_data = wr_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Directed testbench for regfile_2r1w. Expected values are written inline as
// hand-computed constants. Honours REGFILE_WR_BYPASS_EN for the
// read-during-write expectation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [4:0]  rd0_num;
    logic [31:0] rd0_data;
    logic [4:0]  rd1_num;
    logic [31:0] rd1_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    regfile_2r1w #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_num   (wr_num),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd0_num  (rd0_num),
        .rd0_data (rd0_data),
        .rd1_num  (rd1_num),
        .rd1_data (rd1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present a write on the falling edge, let it land on the next rising edge.
    task automatic wr(input logic [4:0] num, input logic [31:0] data);
        @(negedge clk);
        wr_num  = num;
        wr_data = data;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Read both ports combinationally (no clock edge needed).
    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        rd0_num = a0;
        rd1_num = a1;
        #1;
    endtask

    logic [31:0] rdw_exp;

    initial begin
        reset   = 1'b1;
        wr_num  = '0;
        wr_data = '0;
        wr_en   = 1'b0;
        rd0_num = '0;
        rd1_num = '0;

        // Reset pulse between clock edges, then every register reads 0.
        @(posedge clk);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd2(i[4:0], 5'(31 - i));
            check($sformatf("reset_rd0_r%0d", i), rd0_data, 32'h0);
            check($sformatf("reset_rd1_r%0d", 31 - i), rd1_data, 32'h0);
        end

        // Basic write / read on both ports.
        wr(5'd29, 32'h8012_0000);
        wr(5'd31, 32'h0000_0000);
        rd2(5'd29, 5'd31);
        check("wr_r29_rd0", rd0_data, 32'h8012_0000);
        check("wr_r31_rd1", rd1_data, 32'h0000_0000);

        // Both ports on the same register; bit-exact storage.
        wr(5'd10, 32'hA5A5_5A5A);
        rd2(5'd10, 5'd10);
        check("same_r10_rd0", rd0_data, 32'hA5A5_5A5A);
        check("same_r10_rd1", rd1_data, 32'hA5A5_5A5A);
        rd2(5'd10, 5'd29);
        check("indep_r29_rd1", rd1_data, 32'h8012_0000);

        // R0 write discarded.
        wr(5'd0, 32'hDEAD_BEEF);
        rd2(5'd0, 5'd0);
        check("r0_rd0", rd0_data, 32'h0);
        check("r0_rd1", rd1_data, 32'h0);

        // Write enable off.
        wr(5'd5, 32'h1234_5678);
        @(negedge clk);
        wr_num  = 5'd5;
        wr_data = 32'hFFFF_FFFF;
        wr_en   = 1'b0;
        @(posedge clk);
        rd2(5'd5, 5'd5);
        check("wen_off_r5", rd0_data, 32'h1234_5678);

        // Read during write.
        wr(5'd3, 32'd1);
`ifdef REGFILE_WR_BYPASS_EN
        rdw_exp = 32'd2;
`else
        rdw_exp = 32'd1;
`endif
        @(negedge clk);
        wr_num  = 5'd3;
        wr_data = 32'd2;
        wr_en   = 1'b1;
        rd2(5'd3, 5'd3);
        check("rdw_before_rd0", rd0_data, rdw_exp);
        check("rdw_before_rd1", rd1_data, rdw_exp);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("rdw_after_rd0", rd0_data, 32'd2);

        // R0 stays 0 while a write to R0 is presented (bypass case).
        @(negedge clk);
        wr_num  = 5'd0;
        wr_data = 32'hCAFE_F00D;
        wr_en   = 1'b1;
        rd2(5'd0, 5'd0);
        check("r0_bypass_rd0", rd0_data, 32'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("r0_bypass_after", rd1_data, 32'h0);

        // Fill R1..R31 with their index, then spot-check.
        for (int i = 1; i < 32; i++) begin
            wr(i[4:0], 32'(i));
        end
        rd2(5'd1, 5'd31);
        check("fill_r1", rd0_data, 32'd1);
        check("fill_r31", rd1_data, 32'd31);
        rd2(5'd17, 5'd3);
        check("fill_r17", rd0_data, 32'd17);
        check("fill_r3", rd1_data, 32'd3);

        // Asynchronous reset mid-cycle: immediate clear.
        @(posedge clk);
        #2 reset = 1'b0;
        rd2(5'd31, 5'd17);
        check("async_r31_now", rd0_data, 32'h0);
        check("async_r17_now", rd1_data, 32'h0);
        for (int i = 1; i < 32; i++) begin
            rd2(i[4:0], i[4:0]);
            check($sformatf("async_clr_r%0d", i), rd0_data, 32'h0);
        end

        // Write while reset is low is ignored.
        wr(5'd7, 32'd7);
        rd2(5'd7, 5'd7);
        check("wr_in_reset_r7", rd0_data, 32'h0);

        // Release reset mid-cycle; next write lands normally.
        @(negedge clk);
        #2 reset = 1'b1;
        rd2(5'd7, 5'd7);
        check("post_reset_r7", rd1_data, 32'h0);
        wr(5'd7, 32'h0000_0077);
        rd2(5'd7, 5'd8);
        check("post_reset_wr_r7", rd0_data, 32'h0000_0077);
        check("post_reset_r8", rd1_data, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d", chk_cnt);
        $fatal(1);
    end

endmodule
